// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a DEPTH-entry decoupling FIFO.
// It owns the fetch PC, issues sequential word reads to a synchronous-read
// IMEM, and queues {instr, pc} pairs for decode. A redirect flushes the
// queue, squashes the read in flight and restarts fetch at the new PC.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         imem_req,
  output logic [XLEN-1:0]              imem_addr,
  input  logic [31:0]                  imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [XLEN-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] infl_pc_q, infl_pc_d;
  logic            infl_q, infl_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic            pop, push, issue;
  logic [CW:0]     occ;
  logic [XLEN-1:0] redir_addr;
  logic            unused_lsbs;

  // Low address bits of the redirect target are dropped on purpose.
  assign unused_lsbs = ^redirect_pc[1:0];
  assign redir_addr  = {redirect_pc[XLEN-1:2], 2'b00};

  assign out_valid = (count_q != '0) & ~redirect;
  assign pop       = out_valid & out_ready;
  // A response landing in a redirect cycle belongs to the old stream.
  assign push      = infl_q & ~redirect;
  // Every in-flight read has a reserved slot, so the FIFO cannot overflow.
  assign occ       = {1'b0, count_q} + (CW+1)'(infl_q) - (CW+1)'(pop);
  assign issue     = occ < (CW+1)'(DEPTH);
  assign imem_req  = ~rst & (redirect | issue);
  assign imem_addr = redirect ? redir_addr : fetch_pc_q;

  assign out_instr = instr_mem[rd_ptr_q];
  assign out_pc    = pc_mem[rd_ptr_q];
  assign count     = count_q;

  // Next-state: redirect wins; otherwise push/pop/issue update independently.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_pc_d  = infl_pc_q;
    infl_d     = infl_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redir_addr + XLEN'(4);
      infl_d     = 1'b1;
      infl_pc_d  = redir_addr;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        infl_d     = 1'b1;
        infl_pc_d  = fetch_pc_q;
      end else begin
        infl_d     = 1'b0;
      end
    end
  end

  // Control state register; reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      infl_pc_q  <= '0;
      infl_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_pc_q  <= infl_pc_d;
      infl_q     <= infl_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= infl_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard of expected {pc, instr}
// pairs is filled by the stimulus and drained by a negedge monitor on
// every accepted handshake; per-cycle control values are checked inline.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, redirect, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] sb [$];
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .count(count)
  );

  // IMEM model: word n holds 0x1000_0000 + n, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'h1000_0000 + (imem_addr >> 2);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    logic [31:0] ins;
    ins = 32'h1000_0000 + (pc >> 2);
    sb.push_back({pc, ins});
  endtask

  // Monitor: every accepted head entry must match the scoreboard front.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc=%0h instr=%0h expected nothing", out_pc, out_instr);
      end else begin
        mon_exp = sb.pop_front();
        check("pop_data", {out_pc, out_instr}, mon_exp);
      end
    end
  end

  initial begin
    logic [2:0] cnt_tbl [5];
    logic       req_tbl [5];
    cnt_tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    req_tbl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    step(); step();
    check("rst_req",   imem_req,  0);
    check("rst_valid", out_valid, 0);
    check("rst_count", count,     0);

    // Reset release, streaming with out_ready high (cycles 0..7).
    step();
    rst = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 6; n++) expect_pc(32'(4*n));
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      #1;
      check("stream_req",   imem_req,  1);
      check("stream_addr",  imem_addr, 64'(4*c));
      check("stream_valid", out_valid, (c >= 2) ? 1 : 0);
    end
    step();
    out_ready = 1'b0;
    check("stream_drained", sb.size(), 0);

    // Backpressure: count saturates at 4, requests stop (cycles 8..12).
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      #1;
      check("bp_count", count,    cnt_tbl[i]);
      check("bp_req",   imem_req, req_tbl[i]);
    end

    // Full with a single pop (cycles 13..15).
    step();
    out_ready = 1'b1;
    expect_pc(32'd24);
    #1;
    check("full_pop_count", count,     4);
    check("full_pop_req",   imem_req,  1);
    check("full_pop_addr",  imem_addr, 40);
    step();
    out_ready = 1'b0;
    #1;
    check("after_pop_count", count,    3);
    check("after_pop_req",   imem_req, 0);
    step();
    #1;
    check("refill_count", count, 4);

    // Drain in order with no gaps (cycles 16..21).
    step();
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) expect_pc(32'(28 + 4*n));
    #1;
    check("drain_addr", imem_addr, 44);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      #1;
      check("drain_valid", out_valid, 1);
    end

    // Redirect to 0x203 with 3 queued and a read in flight (cycle 22).
    step();
    redirect = 1'b1; redirect_pc = 32'h203;
    for (int n = 0; n < 4; n++) expect_pc(32'(32'h200 + 4*n));
    #1;
    check("redir_count_before", count,     3);
    check("redir_valid",        out_valid, 0);
    check("redir_req",          imem_req,  1);
    check("redir_addr",         imem_addr, 32'h200);
    step();
    redirect = 1'b0;
    #1;
    check("redir_r1_count", count,     0);
    check("redir_r1_valid", out_valid, 0);
    check("redir_r1_addr",  imem_addr, 32'h204);
    step();
    #1;
    check("redir_r2_valid", out_valid, 1);
    check("redir_r2_pc",    out_pc,    32'h200);
    step(); step(); step();

    // Back-to-back redirects to 0x40 then 0x80 (cycles 28..29).
    step();
    check("redir2_sb_empty", sb.size(), 0);
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    check("redir2_valid", out_valid, 0);
    check("redir2_addr",  imem_addr, 32'h40);
    step();
    redirect_pc = 32'h80;
    for (int n = 0; n < 4; n++) expect_pc(32'(32'h80 + 4*n));
    #1;
    check("redir3_addr", imem_addr, 32'h80);
    step();
    redirect = 1'b0;
    #1;
    check("redir3_r1_valid", out_valid, 0);
    check("redir3_r1_count", count,     0);
    step();
    #1;
    check("redir3_r2_valid", out_valid, 1);
    step(); step(); step();
    step();
    out_ready = 1'b0;
    check("redir3_drained", sb.size(), 0);

    // Asynchronous reset mid-stream with count = 2.
    step();
    #1;
    check("pre_rst_count", count, 2);
    rst = 1'b1;
    #1;
    check("async_rst_count", count,     0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_req",   imem_req,  0);
    step(); step();
    rst = 1'b0; out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4);
    #1;
    check("restart_req",   imem_req,  1);
    check("restart_addr",  imem_addr, 0);
    check("restart_valid", out_valid, 0);
    for (int c = 1; c < 4; c++) begin
      step();
      #1;
      check("restart_addr_seq", imem_addr, 64'(4*c));
      check("restart_valid_seq", out_valid, (c >= 2) ? 1 : 0);
    end
    step();
    out_ready = 1'b0;
    check("restart_drained", sb.size(), 0);

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
